// File: rtl/game_pkg.sv
// Shared segment codes, BCD helpers and LFSR tap table for reaction_game_core.
package game_pkg;

  typedef logic [7:0] seg_t;
  typedef logic [3:0] bcd_t;

  localparam int MAX_DIGITS = 8;
  typedef bcd_t [MAX_DIGITS-1:0] bcd_vec_t;

  localparam seg_t SEG_ENEMY = 8'hF1;
  localparam seg_t SEG_NONE  = 8'hF7;
  localparam seg_t SEG_MINUS = 8'hBF;
  localparam seg_t SEG_BLANK = 8'hFF;

  function automatic seg_t seg_of_digit(input bcd_t d);
    seg_t s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One BCD step up or down over the low n digits, wrapping at the ends.
  function automatic bcd_vec_t bcd_step(
    input bcd_vec_t v,
    input logic     up,
    input int       n
  );
    bcd_vec_t r;
    logic     c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (c && i < n) begin
        if (up) begin
          if (v[i] == 4'd9) r[i] = 4'd0;
          else begin
            r[i] = v[i] + 4'd1;
            c    = 1'b0;
          end
        end else begin
          if (v[i] == 4'd0) r[i] = 4'd9;
          else begin
            r[i] = v[i] - 4'd1;
            c    = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Maximal-length Galois masks for a right-shifting LFSR.
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] t;
    case (w)
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0E08;
      13:      t = 32'h0000_1C80;
      14:      t = 32'h0000_3802;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_B400;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0007_2000;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      default: t = 32'h8020_0003;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Sign-magnitude BCD up/down counter: saturating signed score or
// plain wrapping unsigned count.
module bcd_counter
  import game_pkg::*;
#(
  parameter int DIGITS   = 5,
  parameter bit SATURATE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inc,
  input  logic                   dec,
  output logic                   sign,
  output logic [DIGITS-1:0][3:0] digits
);

  bcd_vec_t mag;
  bcd_vec_t up_v;
  bcd_vec_t dn_v;
  bcd_vec_t mag_n;
  logic     sign_n;
  logic     at_max;
  logic     at_zero;
  logic     at_one;

  always_comb begin
    mag = '0;
    mag[DIGITS-1:0] = digits;
    up_v = bcd_step(mag, 1'b1, DIGITS);
    dn_v = bcd_step(mag, 1'b0, DIGITS);
    at_zero = 1'b1;
    at_max  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      at_zero = at_zero & (digits[i] == 4'd0);
      at_max  = at_max  & (digits[i] == 4'd9);
    end
    at_one = (mag == bcd_vec_t'(32'd1));

    sign_n = sign;
    mag_n  = mag;
    if (inc != dec) begin
      if (!SATURATE) begin
        mag_n = inc ? up_v : dn_v;
      end else if (inc ^ sign) begin
        // Moving away from zero: grow magnitude, pin at all nines.
        if (!at_max) mag_n = up_v;
      end else if (at_zero) begin
        mag_n  = up_v;
        sign_n = 1'b1;
      end else begin
        mag_n = dn_v;
        if (at_one) sign_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign   <= 1'b0;
      digits <= '0;
    end else begin
      sign   <= sign_n;
      digits <= mag_n[DIGITS-1:0];
    end
  end

endmodule

// File: rtl/reaction_game_core.sv
// Reaction/target game engine: round timer, LFSR targets, BCD score and test count.
// Define HIT_LATCH_EN to latch any hit seen during the round for scoring.
module reaction_game_core
  import game_pkg::*;
#(
  parameter int                NUM_DIGITS   = 6,
  parameter int                SCORE_DIGITS = 5,
  parameter int                ROUND_TICKS  = 25_000_000,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hit,
  input  logic                       check,
  input  logic                       test,
  output logic                       flash,
  output logic                       round_tk,
  output logic [NUM_DIGITS-1:0][7:0] display
);

  localparam int CNT_W = $clog2(ROUND_TICKS);
  localparam int CRH_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] PRE =
    CNT_W'(ROUND_TICKS - 2);
  localparam logic [LFSR_W-1:0] TAPS =
    LFSR_W'(lfsr_taps(LFSR_W));

  typedef seg_t [NUM_DIGITS-1:0] disp_t;

  logic [1:0] hit_q;
  logic [1:0] check_q;
  logic [1:0] test_q;
  logic       hit_s;
  logic       check_s;
  logic       test_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q   <= '0;
      check_q <= '0;
      test_q  <= '0;
    end else begin
      hit_q   <= {hit_q[0], hit};
      check_q <= {check_q[0], check};
      test_q  <= {test_q[0], test};
    end
  end

  assign hit_s   = hit_q[1];
  assign check_s = check_q[1];
  assign test_s  = test_q[1];

  // round_tk is pre-decoded so it is high exactly in the wrap cycle.
  logic [CNT_W-1:0] cnt;
  logic             tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      round_tk <= 1'b0;
    end else begin
      cnt      <= tick ? '0 : cnt + 1'b1;
      round_tk <= (cnt == PRE);
    end
  end

  assign tick = round_tk;

  logic is_test;
  logic is_play;
  logic is_view;

  assign is_test = test_s;
  assign is_play = check_s & ~test_s;
  assign is_view = ~check_s & ~test_s;

  logic [LFSR_W-1:0]     lfsr;
  logic [LFSR_W-1:0]     next_lfsr;
  logic [NUM_DIGITS-1:0] target;
  logic [NUM_DIGITS-1:0] target_n;
  logic [CRH_W-1:0]      crh;
  logic [CRH_W-1:0]      crh_raw;
  logic [CRH_W-1:0]      crh_n;
  logic                  lastop;
  logic                  hit_eff;
  logic                  correct;

  always_comb begin
    next_lfsr = {1'b0, lfsr[LFSR_W-1:1]};
    if (lfsr[0]) next_lfsr = next_lfsr ^ TAPS;
    target_n = next_lfsr[NUM_DIGITS-1:0];
    crh_raw  = next_lfsr[LFSR_W-1 -: CRH_W];
    crh_n    = crh_raw;
    if (int'(crh_raw) >= NUM_DIGITS)
      crh_n = crh_raw - CRH_W'(NUM_DIGITS);
  end

`ifdef HIT_LATCH_EN
  logic hit_flag;

  always_ff @(posedge clk) begin
    if (!rst_n)     hit_flag <= 1'b0;
    else if (tick)  hit_flag <= 1'b0;
    else if (hit_s) hit_flag <= 1'b1;
  end

  assign hit_eff = hit_flag | hit_s;
`else
  assign hit_eff = hit_s;
`endif

  assign correct = (hit_eff == target[crh]);

  logic                         score_inc;
  logic                         score_dec;
  logic                         test_inc;
  logic                         score_sign;
  logic                         test_sign;
  logic [SCORE_DIGITS-1:0][3:0] score_digits;
  logic [SCORE_DIGITS-1:0][3:0] test_digits;

  assign score_inc = tick & is_play & lastop & correct;
  assign score_dec = tick & is_play & lastop & ~correct;
  assign test_inc  = tick & is_test;

  bcd_counter #(
    .DIGITS   (SCORE_DIGITS),
    .SATURATE (1'b1)
  ) u_score (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (score_inc),
    .dec    (score_dec),
    .sign   (score_sign),
    .digits (score_digits)
  );

  bcd_counter #(
    .DIGITS   (SCORE_DIGITS),
    .SATURATE (1'b0)
  ) u_test (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (test_inc),
    .dec    (1'b0),
    .sign   (test_sign),
    .digits (test_digits)
  );

  function automatic disp_t layout(
    input bcd_vec_t d,
    input logic     neg
  );
    disp_t r;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[i] = SEG_BLANK;
    for (int i = 0; i < SCORE_DIGITS; i++)
      r[i] = seg_of_digit(d[i]);
    r[NUM_DIGITS-1] = neg ? SEG_MINUS : SEG_BLANK;
    return r;
  endfunction

  bcd_vec_t score_v;
  bcd_vec_t test_v;
  bcd_vec_t test_nxt;
  disp_t    play_disp;

  always_comb begin
    score_v = '0;
    score_v[SCORE_DIGITS-1:0] = score_digits;
    test_v = '0;
    test_v[SCORE_DIGITS-1:0] = test_digits;
    test_nxt = bcd_step(test_v, 1'b1, SCORE_DIGITS);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      play_disp[i] = target_n[i] ? SEG_ENEMY : SEG_NONE;
      if (i == int'(crh_n)) play_disp[i][7] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr    <= LFSR_SEED;
      target  <= '0;
      crh     <= '0;
      lastop  <= 1'b0;
      flash   <= 1'b0;
      display <= '1;
    end else if (tick) begin
      flash <= ~flash;
      unique case (1'b1)
        is_test: begin
          display <= layout(test_nxt, test_sign);
          lastop  <= 1'b0;
        end
        is_play: begin
          lfsr    <= next_lfsr;
          target  <= target_n;
          crh     <= crh_n;
          display <= play_disp;
          lastop  <= 1'b1;
        end
        is_view: begin
          display <= layout(score_v, score_sign);
          lastop  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_game_core.sv
// Directed bench for reaction_game_core with 4-cycle rounds, 5- and 2-digit scores.
module tb_reaction_game_core;

  typedef logic [5:0][7:0] disp_t;

  localparam int K_OK    = 0;
  localparam int K_BAD   = 1;
  localparam int K_PULSE = 2;

`ifdef HIT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  rst_n;
  logic  hit;
  logic  check;
  logic  test;
  logic  flash1, flash2;
  logic  rt1, rt2;
  disp_t d1, d2;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reaction_game_core #(.ROUND_TICKS(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hit      (hit),
    .check    (check),
    .test     (test),
    .flash    (flash1),
    .round_tk (rt1),
    .display  (d1)
  );

  reaction_game_core #(.SCORE_DIGITS(2), .ROUND_TICKS(4)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .hit      (hit),
    .check    (check),
    .test     (test),
    .flash    (flash2),
    .round_tk (rt2),
    .display  (d2)
  );

  logic [7:0] segs [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic [15:0] m_lfsr;
  logic [5:0]  m_tgt;
  int          m_crh;
  bit          m_lastop;
  int          m_score, m_score2, m_test, m_ticks;

  task automatic chk48(input string nm, input logic [47:0] a, input logic [47:0] e);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] a, input logic [7:0] e);
    chk48(nm, 48'(a), 48'(e));
  endtask

  function automatic int sat(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic disp_t exp_view(input int s, input int nd);
    disp_t r;
    int    mag;
    r   = '1;
    mag = (s < 0) ? -s : s;
    for (int i = 0; i < nd; i++) begin
      r[i] = segs[mag % 10];
      mag  = mag / 10;
    end
    r[5] = (s < 0) ? 8'hBF : 8'hFF;
    return r;
  endfunction

  function automatic disp_t exp_play();
    disp_t r;
    for (int i = 0; i < 6; i++) r[i] = m_tgt[i] ? 8'hF1 : 8'hF7;
    r[m_crh][7] = 1'b0;
    return r;
  endfunction

  task automatic reset_model();
    m_lfsr = 16'hACE1; m_tgt = '0; m_crh = 0; m_lastop = 0;
    m_score = 0; m_score2 = 0; m_test = 0; m_ticks = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hit = 1'b0; check = 1'b0; test = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
  endtask

  // Starts just after a tick edge; ends just after the next one.
  task automatic run_round(input int kind);
    logic want, good, eff, is_t, is_p;
    int   dl;
    is_t = test;
    is_p = check && !test;
    want = (kind == K_OK) ? m_tgt[m_crh] : ~m_tgt[m_crh];
    for (int c = 0; c < 4; c++) begin
      if (!is_p) hit = 1'b0;
      else if (kind == K_PULSE) hit = (c == 0);
      else hit = (c < 2) ? want : 1'b0;
      if (c == 1) chk8("round_tk idle", 8'(rt1), 8'h0);
      if (c == 3) chk8("round_tk wrap", 8'(rt1), 8'h1);
      @(posedge clk);
      #1;
    end
    hit = 1'b0;
    m_ticks++;
    if (is_t) begin
      m_test   = (m_test + 1) % 100000;
      m_lastop = 0;
      chk48("test disp", d1, exp_view(m_test, 5));
      chk48("test disp2", d2, exp_view(m_test % 100, 2));
    end else if (is_p) begin
      if (m_lastop) begin
        eff  = LATCH;
        good = (kind == K_PULSE) ? (eff == m_tgt[m_crh]) : (kind == K_OK);
        dl   = good ? 1 : -1;
        m_score  = sat(m_score + dl, 99999);
        m_score2 = sat(m_score2 + dl, 99);
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      m_tgt  = m_lfsr[5:0];
      m_crh  = int'(m_lfsr[15:13]);
      if (m_crh >= 6) m_crh = m_crh - 6;
      m_lastop = 1;
      chk48("play disp", d1, exp_play());
      chk48("play disp2", d2, exp_play());
    end else begin
      m_lastop = 0;
      chk48("view disp", d1, exp_view(m_score, 5));
      chk48("view disp2", d2, exp_view(m_score2, 2));
    end
    chk8("flash", 8'(flash1), 8'(m_ticks % 2));
    chk8("flash2", 8'(flash2), 8'(m_ticks % 2));
  endtask

  typedef struct {
    int              cnt;
    logic [2:0][7:0] e1;
    logic [1:0][7:0] e2;
  } tv_t;

  tv_t tv [7];

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by 200us");
    $fatal(1);
  end

  initial begin
    tv[0] = '{cnt: 1,   e1: 24'hC0C0F9, e2: 16'hC0F9};
    tv[1] = '{cnt: 9,   e1: 24'hC0C090, e2: 16'hC090};
    tv[2] = '{cnt: 10,  e1: 24'hC0F9C0, e2: 16'hF9C0};
    tv[3] = '{cnt: 12,  e1: 24'hC0F9A4, e2: 16'hF9A4};
    tv[4] = '{cnt: 99,  e1: 24'hC09090, e2: 16'h9090};
    tv[5] = '{cnt: 100, e1: 24'hF9C0C0, e2: 16'hC0C0};
    tv[6] = '{cnt: 101, e1: 24'hF9C0F9, e2: 16'hC0F9};

    // Reset state, then a reset pulse in the middle of a round.
    do_reset();
    chk48("reset disp", d1, '1);
    chk8("reset flash", 8'(flash1), 8'h0);
    chk8("reset round_tk", 8'(rt1), 8'h0);
    check = 1'b1;
    run_round(K_OK);
    run_round(K_OK);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk48("midreset disp", d1, '1);
    chk8("midreset flash", 8'(flash1), 8'h0);
    chk8("midreset round_tk", 8'(rt1), 8'h0);
    rst_n = 1'b1;
    reset_model();
    check = 1'b0;
    run_round(K_OK);
    chk8("view0 d0", d1[0], 8'hC0);
    chk8("view0 d5", d1[5], 8'hFF);

    // Three hits on target, the first round unscored.
    do_reset();
    check = 1'b1;
    repeat (3) run_round(K_OK);
    check = 1'b0;
    run_round(K_OK);
    chk8("score2 d0", d1[0], 8'hA4);
    chk8("score2 d1", d1[1], 8'hC0);
    chk8("score2 d5", d1[5], 8'hFF);

    // Zero crossing both ways.
    do_reset();
    check = 1'b1;
    run_round(K_OK);
    run_round(K_BAD);
    check = 1'b0;
    run_round(K_OK);
    chk8("neg1 d5", d1[5], 8'hBF);
    chk8("neg1 d0", d1[0], 8'hF9);
    check = 1'b1;
    run_round(K_OK);
    run_round(K_OK);
    check = 1'b0;
    run_round(K_OK);
    chk8("back0 d5", d1[5], 8'hFF);
    chk8("back0 d0", d1[0], 8'hC0);

    // Saturation of the 2-digit score.
    do_reset();
    check = 1'b1;
    run_round(K_OK);
    repeat (101) run_round(K_OK);
    check = 1'b0;
    run_round(K_OK);
    chk48("sat 99", 48'(d2[1:0]), 48'(16'h9090));
    chk48("sat 101", d1, 48'hFFC0C0F9C0F9);
    check = 1'b1;
    run_round(K_OK);
    run_round(K_BAD);
    check = 1'b0;
    run_round(K_OK);
    chk48("sat 98", 48'(d2[1:0]), 48'(16'h9080));
    chk48("sat 100", d1, 48'hFFC0C0F9C0C0);

    // Test-count table; check toggles to show test overrides it.
    do_reset();
    test = 1'b1;
    for (int i = 0; i < 7; i++) begin
      while (m_test < tv[i].cnt) begin
        check = m_test[0];
        run_round(K_OK);
      end
      chk48($sformatf("tcnt[%0d] dut", i), 48'(d1[2:0]), 48'(tv[i].e1));
      chk48($sformatf("tcnt[%0d] dut2", i), 48'(d2[1:0]), 48'(tv[i].e2));
      chk8($sformatf("tcnt[%0d] sign", i), d1[5], 8'hFF);
    end

    // One-cycle hit pulse while the crosshair sits on an enemy.
    do_reset();
    check = 1'b1;
    run_round(K_OK);
    for (int k = 0; k < 64 && m_tgt[m_crh] !== 1'b1; k++)
      run_round(K_OK);
    chk8("pulse armed", d1[m_crh], 8'h71);
    run_round(K_PULSE);
    check = 1'b0;
    run_round(K_OK);
    chk48("pulse score", d1, exp_view(m_score, 5));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
